// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined memory port between the
// instruction-fetch port (read-only) and the data port (read/write).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_addr, i_oe     fetch request (buffered, never back-pressured)
//   i_rdata, i_valid fetch return data and 1-cycle valid pulse
//   d_addr, d_oe     data request address and strobe
//   d_wdata, d_we    store data and byte enables (d_we==0 -> read)
//   d_ready          data request accepted this cycle
//   d_rdata, d_valid load return data and 1-cycle valid pulse
//   m_addr, m_oe     memory request address and strobe
//   m_wdata, m_we    memory store data and byte enables (0 = read)
//   m_rdata, m_valid memory read return, in issue order
//   m_ready          memory accepts a request this cycle
//   err              sticky: read data returned with nothing outstanding

module mem_port_arbiter #(
   parameter int unsigned DEPTH  = 4,
   parameter logic [31:0] I_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_addr,
   input  logic        i_oe,
   output logic [31:0] i_rdata,
   output logic        i_valid,
   input  logic [31:0] d_addr,
   input  logic        d_oe,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_we,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic [31:0] m_addr,
   output logic        m_oe,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_we,
   input  logic [31:0] m_rdata,
   input  logic        m_valid,
   input  logic        m_ready,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_t;

   logic             ipend;
   logic [31:0]      iaddr;
   src_t             last_grant;
   logic [AW:0]      cnt;
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [DEPTH-1:0] tag_q;

   logic [31:0] i_new;
   logic [31:0] i_issue;
   logic        i_cand;
   logic        i_win;
   logic        slot;
   logic        gnt_i;
   logic        gnt_d;
   logic        push;
   logic        pop;

   assign i_new = I_BASE + {16'h0000, i_addr};

   // A fresh fetch with nothing buffered goes straight to the port;
   // otherwise the buffered (older) fetch goes first.
   assign i_cand  = ipend | i_oe;
   assign i_issue = ipend ? iaddr : i_new;

   // A pop in this cycle does not free a slot for this cycle's issue.
   assign slot = m_ready && (cnt < CNT_MAX);

   // Fetch wins alone, or in a tie when data had the last grant.
   assign i_win = i_cand && (!d_oe || last_grant == SRC_D);
   assign gnt_i = !rst && slot && i_win;
   assign gnt_d = !rst && slot && d_oe && !i_win;

   assign push = gnt_i || (gnt_d && d_we == 4'h0);
   assign pop  = !rst && m_valid && (cnt != '0);

   assign d_ready = gnt_d;
   assign m_oe    = gnt_i | gnt_d;
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
   assign i_valid = pop && !tag_q[rptr];
   assign d_valid = pop &&  tag_q[rptr];

   always_comb begin
      m_addr  = i_issue;
      m_wdata = 32'h0;
      m_we    = 4'h0;
      unique case (1'b1)
         gnt_d: begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_we    = d_we;
         end
         gnt_i: begin
            m_addr  = i_issue;
         end
         default: begin
            m_we    = 4'h0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ipend      <= 1'b0;
         iaddr      <= 32'h0;
         last_grant <= SRC_D;
         cnt        <= '0;
         wptr       <= '0;
         rptr       <= '0;
         tag_q      <= '0;
         err        <= 1'b0;
      end else begin
         if (i_oe)
            iaddr <= i_new;
         // Granting a buffered fetch while a new one arrives
         // re-arms the buffer with the new address.
         if (gnt_i)
            ipend <= ipend & i_oe;
         else if (i_oe)
            ipend <= 1'b1;

         if (gnt_i)
            last_grant <= SRC_I;
         else if (gnt_d)
            last_grant <= SRC_D;

         if (push) begin
            tag_q[wptr] <= gnt_d;
            wptr        <= wptr + 1'b1;
         end
         if (pop)
            rptr <= rptr + 1'b1;

         unique case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase

         if (m_valid && cnt == '0)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench for mem_port_arbiter
// against a queue-based reference model.

module tb_mem_port_arbiter;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] I_BASE = 32'h0001_0000;
   localparam int          NCYC   = 4000;

   logic        clk;
   logic        rst;
   logic [15:0] i_addr;
   logic        i_oe;
   logic [31:0] i_rdata;
   logic        i_valid;
   logic [31:0] d_addr;
   logic        d_oe;
   logic [31:0] d_wdata;
   logic [3:0]  d_we;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic [31:0] m_addr;
   logic        m_oe;
   logic [31:0] m_wdata;
   logic [3:0]  m_we;
   logic [31:0] m_rdata;
   logic        m_valid;
   logic        m_ready;
   logic        err;

   mem_port_arbiter #(
      .DEPTH  (DEPTH),
      .I_BASE (I_BASE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_addr  (i_addr),
      .i_oe    (i_oe),
      .i_rdata (i_rdata),
      .i_valid (i_valid),
      .d_addr  (d_addr),
      .d_oe    (d_oe),
      .d_wdata (d_wdata),
      .d_we    (d_we),
      .d_ready (d_ready),
      .d_rdata (d_rdata),
      .d_valid (d_valid),
      .m_addr  (m_addr),
      .m_oe    (m_oe),
      .m_wdata (m_wdata),
      .m_we    (m_we),
      .m_rdata (m_rdata),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h",
                  tag, cyc, got, exp);
      end
   endtask

   // Reference model: outstanding reads as a queue of owners
   // (0 = fetch, 1 = data), one buffered fetch, last winner.
   bit          rq[$];
   bit          f_buf;
   logic [31:0] f_addr;
   bit          last_d;
   bit          s_err;

   initial begin
      rst     = 1'b1;
      i_addr  = '0;
      i_oe    = 1'b0;
      d_addr  = '0;
      d_oe    = 1'b0;
      d_wdata = '0;
      d_we    = '0;
      m_rdata = '0;
      m_valid = 1'b0;
      m_ready = 1'b0;
      f_buf   = 0;
      f_addr  = '0;
      last_d  = 1;
      s_err   = 0;

      for (int i = 0; i < NCYC; i++) begin
         int phase;
         @(negedge clk);
         cyc   = i;
         phase = (i / 100) % 4;

         rst = (i < 2) || ($urandom_range(0, 299) == 0);

         if (phase == 1)
            m_ready = ($urandom_range(0, 3) == 0);
         else
            m_ready = ($urandom_range(0, 3) != 0);

         if (phase == 2)
            m_valid = 1'b0;
         else if (rq.size() > 0)
            m_valid = ($urandom_range(0, 1) == 1);
         else
            m_valid = ($urandom_range(0, 59) == 0);

         i_oe    = ($urandom_range(0, 2) == 0);
         i_addr  = 16'($urandom);
         d_oe    = ($urandom_range(0, 2) == 0);
         d_addr  = $urandom;
         d_wdata = $urandom;
         d_we    = ($urandom_range(0, 1) == 1) ?
                   4'h0 : 4'($urandom);
         m_rdata = $urandom;

         #1;

         check("i_rdata", i_rdata, m_rdata);
         check("d_rdata", d_rdata, m_rdata);

         if (rst) begin
            check("rst_m_oe", 32'(m_oe), 32'd0);
            check("rst_m_we", 32'(m_we), 32'd0);
            check("rst_d_ready", 32'(d_ready), 32'd0);
            check("rst_i_valid", 32'(i_valid), 32'd0);
            check("rst_d_valid", 32'(d_valid), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            rq.delete();
            f_buf  = 0;
            f_addr = '0;
            last_d = 1;
            s_err  = 0;
         end else begin
            int          occ;
            bit          room;
            bit          want_i;
            bit          want_d;
            bit          gi;
            bit          gd;
            bit          ret;
            bit          owner;
            logic [31:0] f_now;

            occ    = rq.size();
            room   = m_ready && (occ < DEPTH);
            want_i = f_buf || i_oe;
            want_d = d_oe;
            gi     = 0;
            gd     = 0;
            if (room) begin
               if (want_i && want_d) begin
                  gi = last_d;
                  gd = !last_d;
               end else begin
                  gi = want_i;
                  gd = want_d;
               end
            end
            f_now = f_buf ? f_addr : I_BASE + 32'(i_addr);

            check("m_oe", 32'(m_oe), 32'(gi | gd));
            check("d_ready", 32'(d_ready), 32'(gd));
            check("m_we", 32'(m_we), gd ? 32'(d_we) : 32'd0);
            if (gi) begin
               check("m_addr_i", m_addr, f_now);
               check("m_wdata_i", m_wdata, 32'd0);
            end
            if (gd) begin
               check("m_addr_d", m_addr, d_addr);
               check("m_wdata_d", m_wdata, d_wdata);
            end

            ret   = m_valid && (occ > 0);
            owner = ret ? rq[0] : 1'b0;
            check("i_valid", 32'(i_valid), 32'(ret && !owner));
            check("d_valid", 32'(d_valid), 32'(ret && owner));
            check("err", 32'(err), 32'(s_err));

            if (ret)
               void'(rq.pop_front());
            if (gi)
               rq.push_back(1'b0);
            if (gd && d_we == 4'h0)
               rq.push_back(1'b1);
            if (m_valid && occ == 0)
               s_err = 1;

            // A new fetch is buffered unless it went out directly.
            if (i_oe && !(gi && !f_buf)) begin
               f_buf  = 1;
               f_addr = I_BASE + 32'(i_addr);
            end else if (gi) begin
               f_buf = 0;
            end

            if (gi)
               last_d = 0;
            if (gd)
               last_d = 1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_cmp, n_bad);
      $finish;
   end

endmodule
